// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   UART_DATA_W               : payload width of one character (8)
//   UART_CLK_PER_BIT_DEFAULT  : default clocks per bit (125 MHz / 115200 baud)
//   rx_state_t                : receiver FSM state encoding
// Configuration macro: UART_RX_PARITY_EN adds the PARITY state (even parity).
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W              = 8;
    localparam int UART_CLK_PER_BIT_DEFAULT = 1085;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } rx_state_t;

endpackage

// File: rtl/sync_ff.sv
// ----------------------------------------------------------------------------
// sync_ff
// Multi-stage flip-flop synchronizer for a single asynchronous bit. All stages
// reset to 1 so an idle-high serial line never shows a false edge at reset.
// Ports:
//   clk    : clock
//   reset_ : asynchronous active-low reset
//   d      : asynchronous input
//   q      : synchronized output (STAGES clocks of latency)
// ----------------------------------------------------------------------------
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage_reg;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            stage_reg <= '1;
        end else begin
            stage_reg <= {stage_reg[STAGES-2:0], d};
        end
    end

    assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// ----------------------------------------------------------------------------
// uart_rx_core
// UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is defined), with a
// one-entry valid/ready output holding register.
// Ports:
//   clk        : clock
//   reset_     : asynchronous active-low reset
//   rx         : asynchronous serial line, idle high
//   rx_data    : received byte, stable while rx_valid=1
//   rx_valid   : rx_data holds an unconsumed byte
//   rx_ready   : consumer accepts the byte when rx_valid=1
//   frame_err  : one-cycle pulse, stop bit sampled low
//   overrun    : one-cycle pulse, good byte dropped because output was full
//   parity_err : one-cycle pulse, even-parity mismatch (0 without parity)
// Configuration macro: UART_RX_PARITY_EN
// ----------------------------------------------------------------------------
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = UART_CLK_PER_BIT_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic                   rx,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic                   frame_err,
    output logic                   overrun,
    output logic                   parity_err
);

    // Start bit is checked at its middle; every later sample is one full bit
    // after the previous one, so all samples land mid-bit.
    localparam logic [15:0] HALF_CNT = 16'(CLK_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_CNT = 16'(CLK_PER_BIT - 1);

    logic                   rxs;
    logic                   rxs_prev_reg;
    rx_state_t              state_reg, state_next;
    logic [15:0]            cnt_reg, cnt_next;
    logic [2:0]             idx_reg, idx_next;
    logic [UART_DATA_W-1:0] shift_reg, shift_next;
    logic                   frame_good;
    logic                   frame_bad;
    logic [UART_DATA_W-1:0] data_reg;
    logic                   valid_reg;
    logic                   frame_err_reg;
    logic                   overrun_reg;
`ifdef UART_RX_PARITY_EN
    logic                   parity_bit_reg, parity_bit_next;
    logic                   parity_bad;
    logic                   parity_err_reg;
`endif

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .reset_ (reset_),
        .d      (rx),
        .q      (rxs)
    );

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            rxs_prev_reg   <= 1'b1;
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            idx_reg        <= '0;
            shift_reg      <= '0;
`ifdef UART_RX_PARITY_EN
            parity_bit_reg <= 1'b0;
`endif
        end else begin
            rxs_prev_reg   <= rxs;
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            shift_reg      <= shift_next;
`ifdef UART_RX_PARITY_EN
            parity_bit_reg <= parity_bit_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg + 16'd1;
        idx_next        = idx_reg;
        shift_next      = shift_reg;
        frame_good      = 1'b0;
        frame_bad       = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bit_next = parity_bit_reg;
        parity_bad      = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                // Only a falling edge starts a frame, so a held-low line
                // (break) cannot retrigger reception.
                if (rxs_prev_reg && !rxs) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (cnt_reg == HALF_CNT) begin
                    if (rxs) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_DATA;
                        cnt_next   = '0;
                        idx_next   = '0;
                    end
                end
            end
            ST_DATA: begin
                if (cnt_reg == FULL_CNT) begin
                    cnt_next   = '0;
                    shift_next = {rxs, shift_reg[UART_DATA_W-1:1]};
                    idx_next   = idx_reg + 3'd1;
                    if (idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_reg == FULL_CNT) begin
                    cnt_next        = '0;
                    parity_bit_next = rxs;
                    state_next      = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_reg == FULL_CNT) begin
                    state_next = ST_IDLE;
                    if (!rxs) begin
                        frame_bad = 1'b1;
`ifdef UART_RX_PARITY_EN
                    // Even parity: data plus parity bit must hold an even
                    // number of ones.
                    end else if (^{shift_reg, parity_bit_reg}) begin
                        parity_bad = 1'b1;
`endif
                    end else begin
                        frame_good = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            data_reg       <= '0;
            valid_reg      <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= 1'b0;
`endif
        end else begin
            frame_err_reg  <= frame_bad;
            overrun_reg    <= frame_good && valid_reg && !rx_ready;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= parity_bad;
`endif
            // A byte consumed in the same cycle a new one completes frees
            // the slot, so the new byte is taken without an overrun.
            if (frame_good && (!valid_reg || rx_ready)) begin
                data_reg  <= shift_reg;
                valid_reg <= 1'b1;
            end else if (valid_reg && rx_ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign rx_data   = data_reg;
    assign rx_valid  = valid_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_reg;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 1085, meaning clocks per bit (125 MHz / 115200 baud); legal range 16..65535.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning flip-flop depth of the rx input synchronizer; legal range 2..4.
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port reset_, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rx, input, 1, asynchronous serial line, idle high, 8N1 framing (8E1 with REQ-026).
REQ-006 SHALL have port rx_data, output, 8, received byte.
REQ-007 SHALL have port rx_valid, output, 1, meaning rx_data holds an unconsumed byte.
REQ-008 SHALL have port rx_ready, input, 1, consumer accept.
REQ-009 SHALL have port frame_err, output, 1, one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port overrun, output, 1, one-cycle pulse when a byte is dropped.
REQ-011 SHALL have port parity_err, output, 1, one-cycle pulse on a parity mismatch.

Function
REQ-012 SHALL pass rx through SYNC_STAGES flip-flops reset to 1 and use only the synchronized value (rxs) internally.
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY and STOP, plus a bit counter and a 3-bit bit index.
REQ-014 IDLE -> START SHALL occur on a 1->0 edge of rxs, with the counter cleared.
REQ-015 In START, at count CLK_PER_BIT/2-1 (integer division), the FSM SHALL sample rxs: if 1 (glitch), go to IDLE with no output; if 0, go to DATA with the counter cleared.
REQ-016 In DATA, every CLK_PER_BIT cycles the FSM SHALL sample rxs into the shift register LSB first; after bit index 7 it SHALL go to STOP (or to PARITY per REQ-026).
REQ-017 In STOP, CLK_PER_BIT cycles after the last sample, the FSM SHALL sample rxs: if 1, the frame is good; if 0, pulse frame_err, discard the byte and enter IDLE.
REQ-018 After the STOP sample the FSM SHALL return to IDLE; a new frame requires a fresh 1->0 edge, so a break condition produces exactly one frame_err.
REQ-019 A good frame SHALL assert rx_valid and present rx_data on the clock edge after the stop-bit sample cycle.
REQ-020 rx_data SHALL stay stable while rx_valid=1, and a byte SHALL be consumed on any cycle with rx_valid=1 and rx_ready=1.
REQ-021 A good frame completing with rx_valid=1 and rx_ready=0 SHALL pulse overrun, drop the new byte and keep the old one.
REQ-022 A good frame completing with rx_valid=1 and rx_ready=1 in the same cycle SHALL load the new byte, keep rx_valid=1 and not pulse overrun.
REQ-023 rx_ready while rx_valid=0 SHALL have no effect.

Reset
REQ-024 Asserting reset_ low SHALL immediately force the FSM to IDLE, clear the counters and shift register, set rx_data=8'h00 and rx_valid/frame_err/overrun/parity_err=0, and set the synchronizer flops to 1.
REQ-025 A reset mid-frame SHALL abort the frame; after release, the block SHALL wait for a fresh 1->0 edge.

Configuration
REQ-026 With macro UART_RX_PARITY_EN defined, the block SHALL receive an even-parity bit after data bit 7 (state PARITY, one bit time); on a good stop bit with parity mismatch it SHALL pulse parity_err, discard the byte and not assert rx_valid.
REQ-027 Without UART_RX_PARITY_EN, the PARITY state SHALL be absent and parity_err SHALL be tied to 0.

Structure
REQ-028 A shared package uart_pkg SHALL hold the FSM state enum typedef, the UART_DATA_W=8 constant and the default CLK_PER_BIT.
REQ-029 The synchronizer SHALL be a sub-module named sync_ff (parameter STAGES, reset value 1).

Verification
REQ-030 Send 0x55 at 1085 clk/bit with rx_ready=1 -> rx_data=0x55 and rx_valid high for exactly 1 cycle, occurring 9.5 bit times (approximately 10307 clk) after the falling edge plus SYNC_STAGES cycles.
REQ-031 Drive a 300-cycle low glitch on rx -> no rx_valid, no frame_err, and the FSM back in IDLE.
REQ-032 Send 0xA3 with stop bit 0, then hold rx low for 20000 cycles -> a single frame_err pulse, no rx_valid.
REQ-033 Send 0x12 then 0x34 with rx_ready=0 -> one overrun pulse and rx_data=0x12; raise rx_ready -> 0x12 consumed and rx_valid falls.
REQ-034 Assert reset_ during data bit 4 of 0xFF, release, then send 0x0F -> only 0x0F is received.
REQ-035 With UART_RX_PARITY_EN: send 0x07 with parity bit 0 -> parity_err pulse and no rx_valid; send 0x07 with parity bit 1 -> rx_data=0x07.
